// File: rtl/fwd_source_pipe_pkg.sv
// Shared types for the EX-stage forwarding source pipeline.
package fwd_source_pipe_pkg;

  localparam int unsigned REC_XLEN = 32;
  localparam int unsigned REC_AW   = 5;

  localparam logic [REC_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [REC_AW-1:0]   rd;
    logic                we;
    logic                is_load;
    logic [REC_XLEN-1:0] data;
  } stage_rec_t;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } load_state_e;

endpackage

// File: rtl/fwd_source_pipe_load_wait_fsm.sv
// Tracks the outstanding MEM-stage load: request, wait stall and captured read data.
module load_wait_fsm
  import fwd_source_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_load_pending,
  input  logic            freeze,
  input  logic            mem_load_ready,
  input  logic [XLEN-1:0] mem_load_data,
  output logic            mem_rd_req_c,
  output logic            load_wait_c,
  output logic [XLEN-1:0] load_data_c
);

  load_state_e     state_q, state_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] cap_q, cap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
    end
  end

  // done_q marks a load whose data arrived while the pipe was frozen.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE:      if (mem_load_pending && !done_q && !mem_load_ready) state_d = LOAD_WAIT;
      LOAD_WAIT: if (mem_load_ready || !mem_load_pending) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (mem_load_pending && !done_q && mem_load_ready) begin
      cap_d = mem_load_data;
      if (freeze) done_d = 1'b1;
    end
    if (!freeze) done_d = 1'b0;
  end

  always_comb begin
    mem_rd_req_c = mem_load_pending && !done_q;
    load_wait_c  = mem_load_pending && !done_q && !mem_load_ready;
    load_data_c  = done_q ? cap_q : mem_load_data;
  end

endmodule

// File: rtl/fwd_source_pipe.sv
// MEM/WB destination records feeding the operand forwarding units, plus load stalls.
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic              flush,
  input  logic              freeze,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic              mem_load_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_valid,
  input  logic              id_rs2_valid,
  output logic              Write_Enable_MEM,
  output logic [REG_AW-1:0] rd_MEM,
  output logic [XLEN-1:0]   Alu_Out_MEM,
  output logic              Write_Enable_WB,
  output logic [REG_AW-1:0] rd_WB,
  output logic [XLEN-1:0]   Loaded_Data_WB,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_rd_req,
  output logic              stall
);

  stage_rec_t      mem_q, wb_q, ex_rec_c;
  logic            load_wait_c, mem_rd_req_c, load_use_c, wb_unused_c;
  logic [XLEN-1:0] load_data_c;

  load_wait_fsm #(.XLEN(XLEN)) u_load_wait_fsm (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_load_pending (mem_q.valid & mem_q.is_load),
    .freeze           (freeze),
    .mem_load_ready   (mem_load_ready),
    .mem_load_data    (mem_load_data),
    .mem_rd_req_c     (mem_rd_req_c),
    .load_wait_c      (load_wait_c),
    .load_data_c      (load_data_c)
  );

  // A write to x0 is never forwardable, so its enable is dropped at capture.
  always_comb begin
    ex_rec_c         = '0;
    ex_rec_c.valid   = ex_valid & ~flush;
    ex_rec_c.rd      = REC_AW'(ex_rd);
    ex_rec_c.we      = ex_we & (ex_rd != REG_AW'(REG_ZERO));
    ex_rec_c.is_load = ex_is_load;
    ex_rec_c.data    = REC_XLEN'(ex_alu_out);
  end

  always_comb begin
    load_use_c = ex_valid && ex_is_load && ex_we && (ex_rd != REG_AW'(REG_ZERO)) &&
                 (((ex_rd == id_rs1) && id_rs1_valid) || ((ex_rd == id_rs2) && id_rs2_valid));
  end

  // freeze holds everything; a waiting load holds MEM and bubbles WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      if (load_wait_c) begin
        wb_q <= '0;
      end else begin
        wb_q.valid   <= mem_q.valid;
        wb_q.rd      <= mem_q.rd;
        wb_q.we      <= mem_q.valid & mem_q.we;
        wb_q.is_load <= mem_q.is_load;
        wb_q.data    <= mem_q.is_load ? REC_XLEN'(load_data_c) : mem_q.data;
        mem_q        <= ex_rec_c;
      end
    end
  end

  always_comb begin
    Write_Enable_MEM = mem_q.valid & mem_q.we & ~mem_q.is_load;
    rd_MEM           = REG_AW'(mem_q.rd);
    Alu_Out_MEM      = XLEN'(mem_q.data);
    mem_addr         = XLEN'(mem_q.data);
    Write_Enable_WB  = wb_q.we;
    rd_WB            = REG_AW'(wb_q.rd);
    Loaded_Data_WB   = XLEN'(wb_q.data);
    mem_rd_req       = mem_rd_req_c;
    stall            = load_use_c | load_wait_c;
    wb_unused_c      = wb_q.valid ^ wb_q.is_load;
  end

endmodule

// File: doc/fwd_source_pipe.md
# fwd_source_pipe

Producer side of the EX-stage operand forwarding bus. Registers the destination record (rd, write enable, result) of each instruction leaving EX through the MEM and WB stages. Drives the MEM-stage and WB-stage forwarding sources that the operand forwarding units compare against rs1/rs2. Also generates the load-use and load-wait stalls that those units cannot resolve by forwarding.

## Interface
Parameters
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a real instruction this cycle
- ex_rd  in  REG_AW  EX destination register
- ex_we  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_alu_out  in  XLEN  EX ALU result (effective address for loads)
- flush  in  1  squash the EX instruction (taken branch/jump)
- freeze  in  1  external pipeline freeze (OR of forwarding-unit Do_Freeze)
- mem_load_data  in  XLEN  data memory read data
- mem_load_ready  in  1  mem_load_data valid this cycle
- id_rs1, id_rs2  in  REG_AW  decode-stage source registers
- id_rs1_valid, id_rs2_valid  in  1  decode sources are used
- Write_Enable_MEM  out  1  MEM-stage result is forwardable
- rd_MEM  out  REG_AW  MEM-stage destination
- Alu_Out_MEM  out  XLEN  MEM-stage ALU result
- Write_Enable_WB  out  1  WB-stage register-file write and forward
- rd_WB  out  REG_AW  WB-stage destination
- Loaded_Data_WB  out  XLEN  WB-stage write data (load data or ALU result)
- mem_addr  out  XLEN  load address, equal to the MEM ALU field
- mem_rd_req  out  1  load request, held until ready
- stall  out  1  hold PC, IF/ID and EX; EX inserts bubble per load_use

## Operation
- MEM record: valid, rd, we, is_load, alu. WB record: we, rd, data.
- Entry capture: each record's we is forced to 0 when rd == 0.
- Write_Enable_MEM is MEM.valid & MEM.we & !MEM.is_load. A load's ALU value is an address and is never forwarded from MEM.
- Write_Enable_WB is WB.we. WB.data is the load data for loads and the ALU result otherwise.
- Load FSM states: IDLE, LOAD_WAIT.
  - IDLE -> LOAD_WAIT when MEM holds a valid load and mem_load_ready is 0.
  - LOAD_WAIT -> IDLE on mem_load_ready.
  - In IDLE, a load whose data is ready in its first MEM cycle completes without a wait cycle.
- mem_rd_req is MEM.valid & MEM.is_load & state-not-completed.
- load_use (combinational) is true when all of the following hold:
  - ex_valid, ex_is_load and ex_we are set, and ex_rd != 0;
  - ex_rd equals id_rs1 with id_rs1_valid set, or equals id_rs2 with id_rs2_valid set.
- stall is load_use | load_wait. load_wait is a MEM load with mem_load_ready still 0.
- Advance rules, in priority order:
  1. freeze: MEM and WB hold; nothing else changes.
  2. load_wait: MEM holds; WB loads a bubble (we = 0). This prevents a duplicate register-file write.
  3. Otherwise: WB takes MEM, with data = mem_load_data for loads and alu otherwise. MEM takes EX with valid = ex_valid & !flush.
- load_use does not hold MEM/WB. The load proceeds normally; the consumer is held in ID for one cycle.
- flush together with freeze or load_wait: the EX entry is not captured. Flush has no effect on MEM/WB.
- Load data capture: mem_load_data is sampled in the cycle mem_load_ready is 1 and carried into WB.

## Timing
- Reset: every record field is 0 and the state is IDLE. All outputs are 0, including stall and mem_rd_req.
- Reset asserted mid-load drops the load; on release the FSM is IDLE.
- EX -> MEM takes 1 cycle and MEM -> WB takes 1 cycle. The ALU result is forwardable from MEM one cycle after EX.
- A single-cycle load's data is in WB one cycle after MEM. Each cycle mem_load_ready is low adds one cycle.
- stall is combinational from the current inputs and state. There is no registered delay.
- freeze is honoured even in LOAD_WAIT. mem_load_data arriving during freeze is captured and the FSM completes. WB update waits for freeze release.

## Structure
- Shared pipeline package:
  - constant REG_ZERO = 0;
  - typedef for the stage record {valid, rd, we, is_load, data};
  - FSM state enum {IDLE, LOAD_WAIT}.
- Sub-module load_wait_fsm: owns the state, mem_rd_req, the load data capture register and load_wait.
- The top level holds the two stage registers, the advance muxing and load_use.

## Test plan
- ALU chain: EX rd=5, we=1, alu=0x0000_0010, no stalls.
  - Cycle 1: Write_Enable_MEM=1, rd_MEM=5, Alu_Out_MEM=0x10.
  - Cycle 2: Write_Enable_WB=1, rd_WB=5, Loaded_Data_WB=0x10.
- rd=0 write: EX rd=0, we=1 -> Write_Enable_MEM=0 and Write_Enable_WB=0 in both later cycles.
- Load-use: EX load rd=7 while ID rs2=7 with id_rs2_valid=1 -> stall=1 for exactly 1 cycle. Write_Enable_MEM=0 while the load is in MEM.
- Slow load: MEM load rd=9, mem_load_ready low for 3 cycles, then data 0xDEAD_BEEF.
  - stall=1 for 3 cycles; WB bubbles meanwhile.
  - Then Write_Enable_WB=1, rd_WB=9, Loaded_Data_WB=0xDEADBEEF for exactly one cycle.
- Flush vs freeze: flush with a valid EX rd=3 -> MEM valid stays 0. freeze=1 for 2 cycles -> MEM/WB outputs unchanged.
- Async reset in LOAD_WAIT: all outputs 0 immediately. After release, stall=0 and mem_rd_req=0.
